// File: rtl/datapath_16.sv
// ---------------------------------------------------------------------------
// datapath_16 -- 16-bit mARC datapath
//
// Holds a 16 x 16 register file (r0 reads as zero, r14 = PC, r15 = IR), a
// 16-function ALU and a 4-bit condition-code register (PSR = n,z,v,c).
// One 20-bit microinstruction is executed per clock.
//
// Ports:
//   clk          in   1  rising-edge clock
//   reset        in   1  synchronous, active-high; clears registers and PSR
//   ctrlword     in  20  {A, B, C, WR, CSEL, AMUX, CMUX, F}
//   instruction  out 16  current IR (r15)
//   status       out  5  {IR[4], n, z, v, c}
//   dataIn       in  16  memory read data / external load value
//   busA         out 16  register A read value (combinational)
//   busB         out 16  register B read value (combinational)
// ---------------------------------------------------------------------------
module datapath_16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] ctrlword,
    output logic [15:0] instruction,
    output logic [4:0]  status,
    input  logic [15:0] dataIn,
    output logic [15:0] busA,
    output logic [15:0] busB
);

    // Register file; entry 0 is only ever cleared, and reads of r0 are forced to zero.
    logic [15:0] regs_r [16];
    logic [3:0]  psr_r;

    logic [3:0]  a_fld_s;
    logic [3:0]  b_fld_s;
    logic [3:0]  c_fld_s;
    logic        wr_s;
    logic        csel_s;
    logic        amux_s;
    logic        cmux_s;
    logic [3:0]  f_s;

    logic [3:0]  a_eff_s;
    logic [3:0]  c_eff_s;
    logic [15:0] cbus_s;
    logic [15:0] alu_res_s;
    logic [16:0] sum_s;
    logic [16:0] diff_s;
    logic        carry_s;
    logic        psr_we_s;
    logic [3:0]  psr_next_s;

    assign a_fld_s = ctrlword[19:16];
    assign b_fld_s = ctrlword[15:12];
    assign c_fld_s = ctrlword[11:8];
    assign wr_s    = ctrlword[7];
    assign csel_s  = ctrlword[6];
    assign amux_s  = ctrlword[5];
    assign cmux_s  = ctrlword[4];
    assign f_s     = ctrlword[3:0];

    // Condition codes for the flag-setting ops; v/c are only meaningful for
    // ADDCC and SUBCC, the logical ops clear them.
    function automatic logic [3:0] calc_psr(
        input logic [3:0]  f,
        input logic [15:0] a,
        input logic [15:0] b,
        input logic [15:0] res,
        input logic        carry
    );
        logic v;
        logic c;
        case (f)
            4'd3: begin
                c = carry;
                v = (a[15] == b[15]) && (res[15] != a[15]);
            end
            4'd9: begin
                c = carry;
                v = (a[15] != b[15]) && (res[15] != a[15]);
            end
            default: begin
                c = 1'b0;
                v = 1'b0;
            end
        endcase
        return {res[15], (res == 16'h0000), v, c};
    endfunction

    // Effective register addresses: AMUX/CMUX take the field from the IR.
    always_comb begin
        if (amux_s) begin
            a_eff_s = {1'b0, regs_r[15][7:5]};
        end else begin
            a_eff_s = a_fld_s;
        end
        if (cmux_s) begin
            c_eff_s = {1'b0, regs_r[15][10:8]};
        end else begin
            c_eff_s = c_fld_s;
        end
    end

    // Combinational read ports with r0 hardwired to zero.
    always_comb begin
        if (a_eff_s == 4'd0) begin
            busA = 16'h0000;
        end else begin
            busA = regs_r[a_eff_s];
        end
        if (b_fld_s == 4'd0) begin
            busB = 16'h0000;
        end else begin
            busB = regs_r[b_fld_s];
        end
    end

    assign sum_s  = {1'b0, busA} + {1'b0, busB};
    // Bit 16 of the widened difference is the unsigned borrow (a < b).
    assign diff_s = {1'b0, busA} - {1'b0, busB};

    // ALU function select.
    always_comb begin
        alu_res_s = 16'h0000;
        case (f_s)
            4'd0, 4'd5:  alu_res_s = busA & busB;
            4'd1, 4'd6:  alu_res_s = busA | busB;
            4'd2, 4'd7:  alu_res_s = ~(busA | busB);
            4'd3, 4'd8:  alu_res_s = sum_s[15:0];
            4'd4:        alu_res_s = busA >> busB[3:0];
            4'd9, 4'd13: alu_res_s = diff_s[15:0];
            4'd10:       alu_res_s = busA << busB[3:0];
            4'd11:       alu_res_s = $signed(busA) >>> busB[3:0];
            4'd12:       alu_res_s = busA ^ busB;
            4'd14:       alu_res_s = {{12{busA[3]}}, busA[3:0]};
            4'd15:       alu_res_s = busA + 16'h0001;
            default:     alu_res_s = 16'h0000;
        endcase
    end

    // Carry source and PSR write enable for the flag-setting functions.
    always_comb begin
        if (f_s == 4'd9) begin
            carry_s = diff_s[16];
        end else begin
            carry_s = sum_s[16];
        end
        case (f_s)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd9: psr_we_s = 1'b1;
            default:                      psr_we_s = 1'b0;
        endcase
    end

    assign psr_next_s = calc_psr(f_s, busA, busB, alu_res_s, carry_s);
    assign cbus_s     = csel_s ? dataIn : alu_res_s;

    // Register file and PSR update; reset wins and suppresses the cycle's write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 16; k++) begin
                regs_r[k] <= 16'h0000;
            end
            psr_r <= 4'h0;
        end else begin
            if (wr_s && (c_eff_s != 4'd0)) begin
                regs_r[c_eff_s] <= cbus_s;
            end
            if (psr_we_s) begin
                psr_r <= psr_next_s;
            end
        end
    end

    assign instruction = regs_r[15];
    assign status      = {regs_r[15][4], psr_r};

endmodule

// File: tb/tb_datapath_16.sv
// ---------------------------------------------------------------------------
// tb_datapath_16 -- self-checking bench for datapath_16.
// Directed table of load/ALU vectors, hand-written sequences for IR load,
// sign extension, INCPC, flags and reset, then randomized microinstructions
// compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_datapath_16;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] ctrlword;
    logic [15:0] dataIn;
    logic [15:0] instruction;
    logic [4:0]  status;
    logic [15:0] busA;
    logic [15:0] busB;

    datapath_16 dut (
        .clk         (clk),
        .reset       (reset),
        .ctrlword    (ctrlword),
        .instruction (instruction),
        .status      (status),
        .dataIn      (dataIn),
        .busA        (busA),
        .busB        (busB)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [15:0] m_regs [16];
    logic [3:0]  m_psr;

    typedef struct {
        logic [19:0] cw;
        logic [15:0] din;
        logic [3:0]  idx;
        logic [15:0] exp_val;
        logic [4:0]  exp_st;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_rd(input logic [3:0] idx);
        return (idx == 4'd0) ? 16'h0000 : m_regs[idx];
    endfunction

    function automatic logic [3:0] m_aidx(input logic [19:0] cw);
        return cw[5] ? {1'b0, m_regs[15][7:5]} : cw[19:16];
    endfunction

    function automatic int to_signed(input int u);
        return (u >= 32'sd32768) ? u - 32'sd65536 : u;
    endfunction

    function automatic bit out_of_range(input int s);
        return (s > 32'sd32767) || (s < -32'sd32768);
    endfunction

    task automatic model_step(input logic [19:0] cw, input logic [15:0] din, input logic rst);
        int a, b, sa, sb, s, r, res;
        logic [3:0] op;
        logic [3:0] cidx;
        logic vv, cv;
        if (rst) begin
            for (int k = 0; k < 16; k++) m_regs[k] = 16'h0000;
            m_psr = 4'h0;
        end else begin
            op   = cw[3:0];
            a    = int'(m_rd(m_aidx(cw)));
            b    = int'(m_rd(cw[15:12]));
            sa   = to_signed(a);
            sb   = to_signed(b);
            s    = b % 32'sd16;
            cidx = cw[4] ? {1'b0, m_regs[15][10:8]} : cw[11:8];
            case (op)
                4'd0, 4'd5:  r = a & b;
                4'd1, 4'd6:  r = a | b;
                4'd2, 4'd7:  r = 32'sd65535 - (a | b);
                4'd3, 4'd8:  r = a + b;
                4'd4:        r = a >> s;
                4'd9, 4'd13: r = a - b;
                4'd10:       r = a << s;
                4'd11:       r = sa >>> s;
                4'd12:       r = a ^ b;
                4'd14:       r = ((a % 32'sd16) >= 32'sd8) ? (a % 32'sd16) - 32'sd16 : (a % 32'sd16);
                4'd15:       r = a + 32'sd1;
                default:     r = 32'sd0;
            endcase
            res = r & 32'sd65535;
            vv  = 1'b0;
            cv  = 1'b0;
            if (op == 4'd3) begin
                cv = (a + b) > 32'sd65535;
                vv = out_of_range(sa + sb);
            end
            if (op == 4'd9) begin
                cv = a < b;
                vv = out_of_range(sa - sb);
            end
            if (op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd9})
                m_psr = {res >= 32'sd32768, res == 32'sd0, vv, cv};
            if (cw[7] && cidx != 4'd0)
                m_regs[cidx] = cw[6] ? din : res[15:0];
        end
    endtask

    task automatic step(input logic [19:0] cw, input logic [15:0] din, input logic rst);
        @(negedge clk);
        ctrlword = cw;
        dataIn   = din;
        reset    = rst;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_step(cw, din, rst);
    endtask

    // Read register idx on both buses without changing any state (F=AND, WR=0).
    task automatic peek(input string name, input logic [3:0] idx, input logic [15:0] exp);
        ctrlword = {idx, idx, 12'h005};
        #1;
        check({name, ".busA"}, {16'h0000, busA}, {16'h0000, exp});
        check({name, ".busB"}, {16'h0000, busB}, {16'h0000, exp});
    endtask

    initial begin
        logic [19:0] cw;
        logic [15:0] din;
        logic        rst;
        logic [3:0]  ii;

        reset    = 1'b0;
        ctrlword = 20'h00000;
        dataIn   = 16'h0000;

        // Reset state
        step(20'h00000, 16'h0000, 1'b1);
        check("reset.instruction", {16'h0000, instruction}, 32'h0000_0000);
        check("reset.status", {27'h0, status}, 32'h0000_0000);
        peek("reset.r15", 4'd15, 16'h0000);

        // Load sweep then ALU sweep; every load row runs ANDCC on zeros -> z=1.
        for (int i = 0; i < 16; i++) begin
            ii = 4'(i);
            vecs[i].cw      = {ii, ii, ii, 8'hC0};
            vecs[i].din     = 16'h0001 << i;
            vecs[i].idx     = ii;
            vecs[i].exp_val = (i == 0) ? 16'h0000 : (16'h0001 << i);
            vecs[i].exp_st  = 5'b00100;
        end
        vecs[16] = '{cw: {4'd3,  4'd3,  4'd3,  8'h83}, din: 16'h0000, idx: 4'd3,  exp_val: 16'h0010, exp_st: 5'b00000};
        vecs[17] = '{cw: {4'd2,  4'd2,  4'd2,  8'h82}, din: 16'h0000, idx: 4'd2,  exp_val: 16'hFFFB, exp_st: 5'b01000};
        vecs[18] = '{cw: {4'd12, 4'd12, 4'd12, 8'h8C}, din: 16'h0000, idx: 4'd12, exp_val: 16'h0000, exp_st: 5'b01000};
        vecs[19] = '{cw: {4'd8,  4'd8,  4'd8,  8'h88}, din: 16'h0000, idx: 4'd8,  exp_val: 16'h0200, exp_st: 5'b01000};

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].cw, vecs[i].din, 1'b0);
            check($sformatf("vec%0d.status", i), {27'h0, status}, {27'h0, vecs[i].exp_st});
            peek($sformatf("vec%0d", i), vecs[i].idx, vecs[i].exp_val);
        end

        // IR load and sign extension
        step(20'h00FC0, 16'h2338, 1'b0);
        check("irload.instruction", {16'h0000, instruction}, 32'h0000_2338);
        check("irload.status", {27'h0, status}, {27'h0, 5'b10100});
        step(20'hF0D8E, 16'h0000, 1'b0);
        peek("sext.r13", 4'd13, 16'hFFF8);

        // INCPC leaves the PSR alone
        step(20'h00EC5, 16'h4000, 1'b0);
        step(20'hE0E8F, 16'h0000, 1'b0);
        peek("incpc.r14", 4'd14, 16'h4001);
        check("incpc.status", {27'h0, status}, {27'h0, 5'b10100});

        // ADDCC 0x8000 + 0x8000: zero, overflow, carry
        step(20'h001C5, 16'h8000, 1'b0);
        step(20'h002C5, 16'h8000, 1'b0);
        step(20'h12383, 16'h0000, 1'b0);
        peek("flags.r3", 4'd3, 16'h0000);
        check("flags.status", {27'h0, status}, {27'h0, 5'b10111});

        // Reset mid-sequence with a pending load of r5 and ADDCC
        step(20'h555C3, 16'hFFFF, 1'b1);
        check("rstmid.instruction", {16'h0000, instruction}, 32'h0000_0000);
        check("rstmid.status", {27'h0, status}, 32'h0000_0000);
        for (int k = 1; k < 16; k++) begin
            peek($sformatf("rstmid.r%0d", k), 4'(k), 16'h0000);
        end

        // Randomized microinstructions against the reference model
        for (int n = 0; n < 800; n++) begin
            cw  = 20'($urandom);
            din = 16'($urandom);
            rst = ($urandom_range(0, 63) == 0);
            step(cw, din, rst);
            check($sformatf("rnd%0d.busA", n), {16'h0000, busA}, {16'h0000, m_rd(m_aidx(cw))});
            check($sformatf("rnd%0d.busB", n), {16'h0000, busB}, {16'h0000, m_rd(cw[15:12])});
            check($sformatf("rnd%0d.instruction", n), {16'h0000, instruction}, {16'h0000, m_regs[15]});
            check($sformatf("rnd%0d.status", n), {27'h0, status}, {27'h0, m_regs[15][4], m_psr});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
